// File: rtl/neuron_vec_if.sv
// Stream interface for neuron_vec: input beats toward the neuron and results back out.
// The master side drives beats and out_ready; the slave side is the neuron itself.
interface neuron_vec_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/neuron_vec.sv
// Fixed-point vector neuron: LANES-wide MAC over NUM_WEIGHT stored weights, plus bias,
// then shift, saturate and optional ReLU before a held valid/ready output.
module neuron_vec #(
    parameter int    DATA_W     = 16,
    parameter int    FRAC_W     = 8,
    parameter int    NUM_WEIGHT = 128,
    parameter int    LANES      = 4,
    parameter int    LAYER_NO   = 1,
    parameter int    NEURON_NO  = 0,
    parameter string ACT        = "relu"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cfg_layer,
    input  logic [31:0]       cfg_neuron,
    input  logic              w_valid,
    input  logic [DATA_W-1:0] w_data,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    neuron_vec_if.slave       s,
    output logic              busy,
    output logic              err_len
);
    localparam int ROWS    = NUM_WEIGHT / LANES;
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PROD_W  = 2 * DATA_W;
    localparam int ACC_W   = PROD_W + $clog2(NUM_WEIGHT);
    localparam bit IS_RELU = (ACT == "relu");

    localparam logic [ROW_W-1:0]        LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]        ROW_ONE   = ROW_W'(1);
    localparam logic [LANE_W-1:0]       LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0]       LANE_ONE  = LANE_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MAX   = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN   = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        DRAIN = 3'd2,
        BIAS  = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t                   state_r, state_next_s;
    logic signed [DATA_W-1:0] wmem_r [LANES][ROWS];
    logic [LANE_W-1:0]        wr_lane_r;
    logic [ROW_W-1:0]         wr_row_r;
    logic [ROW_W-1:0]         beat_cnt_r;
    logic                     drain_cnt_r;
    logic signed [PROD_W-1:0] prod_r [LANES];
    logic                     prod_vld_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  bias_r;
    logic signed [ACC_W-1:0]  lane_sum_s;
    logic signed [ACC_W-1:0]  shifted_s;
    logic [DATA_W-1:0]        result_s;
    logic [DATA_W-1:0]        out_data_r;
    logic                     in_ready_r, out_valid_r, busy_r, err_len_r;
    logic                     match_s, accept_s, final_beat_s, wr_en_s;

    assign match_s      = (cfg_layer == 32'(LAYER_NO)) && (cfg_neuron == 32'(NEURON_NO));
    assign accept_s     = s.in_valid && in_ready_r;
    assign final_beat_s = (beat_cnt_r == LAST_ROW);
    assign wr_en_s      = w_valid && match_s && (state_r == IDLE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // FSM next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = final_beat_s ? DRAIN : ACC;
                else          state_next_s = IDLE;
            end
            ACC: begin
                if (accept_s && final_beat_s) state_next_s = DRAIN;
                else                          state_next_s = ACC;
            end
            DRAIN: begin
                if (drain_cnt_r) state_next_s = BIAS;
                else             state_next_s = DRAIN;
            end
            BIAS:    state_next_s = OUT;
            OUT: begin
                if (out_valid_r && s.out_ready) state_next_s = IDLE;
                else                            state_next_s = OUT;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Write pointer walks lanes first so index i lands in bank i%LANES, row i/LANES
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_lane_r <= {LANE_W{1'b0}};
            wr_row_r  <= {ROW_W{1'b0}};
        end else if (wr_en_s) begin
            if (wr_lane_r == LAST_LANE) begin
                wr_lane_r <= {LANE_W{1'b0}};
                wr_row_r  <= (wr_row_r == LAST_ROW) ? {ROW_W{1'b0}} : wr_row_r + ROW_ONE;
            end else begin
                wr_lane_r <= wr_lane_r + LANE_ONE;
            end
        end
    end

    // Weight banks and bias survive rst so a frame can restart without reloading
    always_ff @(posedge clk) begin
        if (wr_en_s) wmem_r[wr_lane_r][wr_row_r] <= w_data;
        if (b_valid && match_s) bias_r <= ACC_W'($signed(b_data)) <<< FRAC_W;
    end

    // Product stage: the accepted beat against the weight row selected by the beat count
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_vld_r <= 1'b0;
            for (int l = 0; l < LANES; l++) prod_r[l] <= {PROD_W{1'b0}};
        end else begin
            prod_vld_r <= accept_s;
            for (int l = 0; l < LANES; l++)
                prod_r[l] <= PROD_W'($signed(s.in_data[l*DATA_W +: DATA_W])) *
                             PROD_W'(wmem_r[l][beat_cnt_r]);
        end
    end

    // Beat counting and sticky frame-length check
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_r <= {ROW_W{1'b0}};
            err_len_r  <= 1'b0;
        end else if (accept_s) begin
            beat_cnt_r <= final_beat_s ? {ROW_W{1'b0}} : beat_cnt_r + ROW_ONE;
            if (s.in_last != final_beat_s) err_len_r <= 1'b1;
        end
    end

    // Adder tree across lanes, sign-extended to accumulator width
    always_comb begin
        lane_sum_s = {ACC_W{1'b0}};
        for (int l = 0; l < LANES; l++) lane_sum_s = lane_sum_s + ACC_W'(prod_r[l]);
    end

    // Accumulator: cleared by the first beat, then products, then bias once
    always_ff @(posedge clk) begin
        if (rst)                               acc_r <= {ACC_W{1'b0}};
        else if (accept_s && state_r == IDLE)  acc_r <= {ACC_W{1'b0}};
        else if (prod_vld_r)                   acc_r <= acc_r + lane_sum_s;
        else if (state_r == BIAS)              acc_r <= acc_r + bias_r;
    end

    // Drain timer: two cycles so the last products land before the bias
    always_ff @(posedge clk) begin
        if (rst) drain_cnt_r <= 1'b0;
        else     drain_cnt_r <= (state_r == DRAIN) ? ~drain_cnt_r : 1'b0;
    end

    // Rescale with truncation toward minus infinity, then clamp or rectify
    always_comb begin
        shifted_s = acc_r >>> FRAC_W;
        if (IS_RELU && shifted_s[ACC_W-1]) result_s = {DATA_W{1'b0}};
        else if (shifted_s > SAT_MAX)      result_s = SAT_MAX[DATA_W-1:0];
        else if (shifted_s < SAT_MIN)      result_s = SAT_MIN[DATA_W-1:0];
        else                               result_s = shifted_s[DATA_W-1:0];
    end

    // Registered handshake outputs; out_data is captured once on entering OUT
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else begin
            in_ready_r <= (state_next_s == IDLE) || (state_next_s == ACC);
            busy_r     <= (state_next_s != IDLE);
            if (state_r == OUT) begin
                if (out_valid_r && s.out_ready) begin
                    out_valid_r <= 1'b0;
                end else begin
                    out_valid_r <= 1'b1;
                    if (!out_valid_r) out_data_r <= result_s;
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign s.in_ready  = in_ready_r;
    assign s.out_valid = out_valid_r;
    assign s.out_data  = out_data_r;
    assign busy        = busy_r;
    assign err_len     = err_len_r;
endmodule

// File: tb/tb_neuron_vec.sv
// Scoreboard bench: a relu and a linear neuron share every input; a monitor per instance
// pops the expected result at each output handshake.
module tb_neuron_vec;
    localparam int DATA_W     = 16;
    localparam int FRAC_W     = 8;
    localparam int NUM_WEIGHT = 8;
    localparam int LANES      = 4;
    localparam logic [63:0] ONES = 64'h0100_0100_0100_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_layer, cfg_neuron;
    logic        w_valid, b_valid;
    logic [15:0] w_data, b_data;
    logic        in_valid, in_last, out_ready;
    logic [63:0] in_data;
    logic        busy_rl, err_rl, busy_ln, err_ln;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_r_q[$];
    logic [15:0] exp_l_q[$];

    always #5 clk = ~clk;

    neuron_vec_if #(.DATA_W(DATA_W), .LANES(LANES)) if_r ();
    neuron_vec_if #(.DATA_W(DATA_W), .LANES(LANES)) if_l ();

    assign if_r.in_valid  = in_valid;
    assign if_r.in_data   = in_data;
    assign if_r.in_last   = in_last;
    assign if_r.out_ready = out_ready;
    assign if_l.in_valid  = in_valid;
    assign if_l.in_data   = in_data;
    assign if_l.in_last   = in_last;
    assign if_l.out_ready = out_ready;

    neuron_vec #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .NUM_WEIGHT(NUM_WEIGHT), .LANES(LANES),
                 .LAYER_NO(1), .NEURON_NO(0), .ACT("relu")) dut_relu (
        .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
        .w_valid(w_valid), .w_data(w_data), .b_valid(b_valid), .b_data(b_data),
        .s(if_r), .busy(busy_rl), .err_len(err_rl));

    neuron_vec #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .NUM_WEIGHT(NUM_WEIGHT), .LANES(LANES),
                 .LAYER_NO(1), .NEURON_NO(0), .ACT("linear")) dut_lin (
        .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
        .w_valid(w_valid), .w_data(w_data), .b_valid(b_valid), .b_data(b_data),
        .s(if_l), .busy(busy_ln), .err_len(err_ln));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitors: compare each accepted output against the scoreboard head
    always @(negedge clk) begin
        if (!rst && out_ready && if_r.out_valid) begin
            if (exp_r_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL relu_unexpected_out: got %0h expected none", if_r.out_data);
            end else begin
                check("relu_out", 32'(if_r.out_data), 32'(exp_r_q.pop_front()));
            end
        end
        if (!rst && out_ready && if_l.out_valid) begin
            if (exp_l_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL lin_unexpected_out: got %0h expected none", if_l.out_data);
            end else begin
                check("lin_out", 32'(if_l.out_data), 32'(exp_l_q.pop_front()));
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 50 && busy_rl; k++) begin @(posedge clk); #1; end
        if (busy_rl) begin
            n_checks++; n_fail++;
            $display("FAIL idle_timeout: got busy=1 expected 0");
        end
    endtask

    task automatic write_w(input logic [15:0] d);
        wait_idle();
        w_valid = 1'b1; w_data = d;
        @(posedge clk); #1;
        w_valid = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] d);
        for (int i = 0; i < NUM_WEIGHT; i++) write_w(d);
    endtask

    task automatic set_bias(input logic [15:0] d);
        b_valid = 1'b1; b_data = d;
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last);
        for (int k = 0; k < 50 && !if_r.in_ready; k++) begin @(posedge clk); #1; end
        if (!if_r.in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1");
        end
        in_valid = 1'b1; in_data = d; in_last = last;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic check_latency(input int start);
        int lat;
        lat = start;
        while (!if_r.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("latency", 32'(lat), 32'd4);
        check("lin_valid_align", 32'(if_l.out_valid), 32'd1);
    endtask

    task automatic frame(input logic [63:0] b0, input logic [63:0] b1,
                         input logic [15:0] er, input logic [15:0] el);
        exp_r_q.push_back(er);
        exp_l_q.push_back(el);
        send_beat(b0, 1'b0);
        send_beat(b1, 1'b1);
        check_latency(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1; cfg_layer = 32'd1; cfg_neuron = 32'd0;
        w_valid = 1'b0; w_data = 16'h0000; b_valid = 1'b0; b_data = 16'h0000;
        in_valid = 1'b0; in_data = 64'h0; in_last = 1'b0; out_ready = 1'b1;

        @(posedge clk); #1;
        check("rst_out_valid", 32'(if_r.out_valid), 32'd0);
        check("rst_out_data",  32'(if_r.out_data),  32'd0);
        check("rst_busy",      32'(busy_rl),        32'd0);
        check("rst_err_len",   32'(err_rl),         32'd0);
        check("rst_in_ready",  32'(if_r.in_ready),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(if_r.in_ready), 32'd1);

        // Unit weights and half bias: 8.0 + 0.5
        load_all(16'h0100);
        set_bias(16'h0080);
        frame(ONES, ONES, 16'h0880, 16'h0880);
        check("err_len_clean", 32'(err_rl), 32'd0);

        // Negative sum: rectified vs passed through
        load_all(16'hFF00);
        set_bias(16'h0000);
        frame(ONES, ONES, 16'h0000, 16'hF800);

        // Positive and negative saturation
        load_all(16'h7F00);
        frame(64'h7F00_7F00_7F00_7F00, 64'h7F00_7F00_7F00_7F00, 16'h7FFF, 16'h7FFF);
        load_all(16'h8000);
        frame(64'h7F00_7F00_7F00_7F00, 64'h7F00_7F00_7F00_7F00, 16'h0000, 16'h8000);

        // Distinct weights per index: w1*0.5 - w3 + 2*w7 + 0.5 = 12.0
        for (int i = 0; i < NUM_WEIGHT; i++) write_w(16'(i << 8));
        set_bias(16'h0080);
        frame(64'hFF00_0000_0080_0100, 64'h0200_0000_0000_0000, 16'h0C00, 16'h0C00);

        // Tiny negative product: arithmetic shift floors to -1
        load_all(16'h0001);
        set_bias(16'h0000);
        frame(64'h0000_0000_0000_FFFF, 64'h0, 16'h0000, 16'hFFFF);

        // Bias written during the BIAS cycle: old bias now, new bias next frame
        load_all(16'h0100);
        set_bias(16'h0080);
        exp_r_q.push_back(16'h0880);
        exp_l_q.push_back(16'h0880);
        send_beat(ONES, 1'b0);
        send_beat(ONES, 1'b1);
        repeat (2) @(posedge clk);
        #1; b_valid = 1'b1; b_data = 16'h0100;
        @(posedge clk); #1; b_valid = 1'b0;
        check_latency(3);
        frame(ONES, ONES, 16'h0900, 16'h0900);
        set_bias(16'h0080);

        // Output stall with ignored beats and dropped weight writes
        out_ready = 1'b0;
        exp_r_q.push_back(16'h0880);
        exp_l_q.push_back(16'h0880);
        send_beat(ONES, 1'b0);
        send_beat(ONES, 1'b1);
        check_latency(0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = {$urandom, $urandom};
            w_valid = 1'b1; w_data = 16'h1234;
            @(posedge clk); #1;
            check("stall_valid",    32'(if_r.out_valid), 32'd1);
            check("stall_data",     32'(if_r.out_data),  32'h0880);
            check("stall_lin_data", 32'(if_l.out_data),  32'h0880);
            check("stall_in_ready", 32'(if_r.in_ready),  32'd0);
        end
        in_valid = 1'b0; w_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_valid_drop", 32'(if_r.out_valid), 32'd0);
        check("hs_idle",       32'(busy_rl),        32'd0);
        check("hs_in_ready",   32'(if_r.in_ready),  32'd1);
        frame(ONES, ONES, 16'h0880, 16'h0880);

        // Writes and bias for another neuron or layer must not land
        cfg_neuron = 32'd1;
        load_all(16'h2000);
        set_bias(16'h4000);
        cfg_neuron = 32'd0; cfg_layer = 32'd2;
        load_all(16'h3000);
        cfg_layer = 32'd1;
        frame(ONES, ONES, 16'h0880, 16'h0880);

        // Reset mid-frame abandons the frame, memory retained
        send_beat(ONES, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy",     32'(busy_rl),        32'd0);
        check("midrst_in_ready", 32'(if_r.in_ready),  32'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (if_r.out_valid || if_l.out_valid) seen++;
        end
        check("midrst_no_output", 32'(seen), 32'd0);
        frame(ONES, ONES, 16'h0880, 16'h0880);

        // Early in_last: frame still completes, err_len sticks until rst
        exp_r_q.push_back(16'h0880);
        exp_l_q.push_back(16'h0880);
        send_beat(ONES, 1'b1);
        send_beat(ONES, 1'b1);
        check_latency(0);
        check("err_len_set",     32'(err_rl), 32'd1);
        check("err_len_set_lin", 32'(err_ln), 32'd1);
        frame(ONES, ONES, 16'h0880, 16'h0880);
        check("err_len_held", 32'(err_rl), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("err_len_cleared", 32'(err_rl), 32'd0);
        rst = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("relu_queue_empty", 32'(exp_r_q.size()), 32'd0);
        check("lin_queue_empty",  32'(exp_l_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/neuron_vec.md
NEURON_VEC -- requirements
Module: neuron_vec

Interface
REQ-001 Parameter DATA_W, default 16: signed two's-complement width of weights, inputs, bias and output.
REQ-002 Parameter FRAC_W, default 8: fractional bits of every fixed-point operand.
REQ-003 Parameter NUM_WEIGHT, default 128: weights per neuron; SHALL be an integer multiple of LANES.
REQ-004 Parameter LANES, default 4: parallel MAC lanes per input beat.
REQ-005 Parameter LAYER_NO, default 1; parameter NEURON_NO, default 0: configuration select identity.
REQ-006 Parameter ACT, default "relu": activation, "relu" or "linear".
REQ-007 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 cfg_layer, cfg_neuron  input  32 each  configuration target select.
REQ-010 w_valid  input  1; w_data  input  DATA_W  sequential weight load.
REQ-011 b_valid  input  1; b_data  input  DATA_W  bias load.
REQ-012 in_valid  input  1; in_ready  output  1; in_data  input  LANES*DATA_W  input beat, lane 0 in LSBs; in_last  input  1  frame end marker.
REQ-013 out_valid  output  1; out_ready  input  1; out_data  output  DATA_W  result.
REQ-014 busy  output  1  FSM not in IDLE; err_len  output  1  sticky frame-length error.

Function
REQ-015 Select match SHALL be cfg_layer==LAYER_NO and cfg_neuron==NEURON_NO.
REQ-016 Weight write SHALL occur on w_valid & match & FSM in IDLE; write pointer starts at 0, increments per write, wraps NUM_WEIGHT-1 -> 0; writes outside IDLE SHALL be dropped.
REQ-017 Weight index i SHALL be stored in bank i mod LANES, row i/LANES, so that one row feeds all lanes in one cycle.
REQ-018 Bias SHALL latch on b_valid & match (any state), sign-extended and shifted left FRAC_W into accumulator width.
REQ-019 Accumulator width ACC_W SHALL be 2*DATA_W+clog2(NUM_WEIGHT); no wrap possible.
REQ-020 FSM states: IDLE, ACC, DRAIN, BIAS, OUT.
REQ-021 IDLE: in_ready=1; accepted beat (in_valid&in_ready) SHALL clear accumulator, load beat 0, go to ACC.
REQ-022 ACC: in_ready=1; beat counter increments per accepted beat; acceptance of beat NUM_WEIGHT/LANES-1 SHALL go to DRAIN.
REQ-023 Lane products SHALL be registered one cycle after acceptance and summed into the accumulator the following cycle.
REQ-024 DRAIN lasts 2 cycles (pipeline flush), then BIAS (1 cycle, adds bias), then OUT.
REQ-025 OUT: in_ready=0; out_valid=1; out_data held stable until out_ready; out_valid&out_ready SHALL return to IDLE.
REQ-026 Latency: out_valid SHALL rise on the 4th rising edge after the edge accepting the final beat, with out_ready held high.
REQ-027 out_data = accumulator arithmetic-shifted right FRAC_W (truncation), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; with ACT="relu", negative results SHALL give 0.
REQ-028 err_len SHALL set if in_last=1 on a non-final beat or 0 on the final beat; frame still completes on beat count; err_len clears only on rst.
REQ-029 in_valid with in_ready=0 SHALL be ignored; data need not be held by the source.
REQ-030 Bias load in the same cycle as BIAS state: old bias SHALL be used.

Reset
REQ-031 rst SHALL force FSM to IDLE, write pointer, beat counter and accumulator to 0, out_valid=0, out_data=0, busy=0, err_len=0, in_ready=0 during the rst cycle, in_ready=1 the cycle after.
REQ-032 rst mid-frame SHALL abandon the frame with no out_valid; weight memory and bias contents are retained.

Verification (DATA_W=16, FRAC_W=8, NUM_WEIGHT=8, LANES=4)
REQ-033 Load 8 weights 0x0100, bias 0x0080, two beats all lanes 0x0100, in_last on beat 2 -> out_data=0x0880 exactly 4 edges after beat 2, err_len=0.
REQ-034 ACT="relu", weights 0xFF00, inputs 0x0100, bias 0 -> out_data=0x0000; ACT="linear" -> 0xF800.
REQ-035 ACT="linear", weights 0x7F00, inputs 0x7F00 -> out_data=0x7FFF (saturated).
REQ-036 out_ready low 5 cycles in OUT -> out_valid and out_data held, in_ready=0; one-cycle handshake then IDLE.
REQ-037 rst asserted after beat 1 -> no out_valid; new frame without reloading weights -> correct result 0x0880.
REQ-038 w_valid with cfg_neuron!=NEURON_NO, or in_last on beat 1 -> weights unchanged; err_len=1 and held until rst.
